// File: rtl/logical_unit_if.sv
// Request/response bundle for logical_unit_mc: issue-side request plus the
// registered result channel. Port directions are named from the unit's view.
interface logical_unit_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [3:0]      funct_i;
  logic            is_branch_op_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] res_o;
  logic            branch_taken_o;
  logic            illegal_o;

  modport slave (
    input  valid_i, funct_i, is_branch_op_i, op1_i, op2_i, ready_i,
    output ready_o, valid_o, res_o, branch_taken_o, illegal_o
  );

  modport master (
    output valid_i, funct_i, is_branch_op_i, op1_i, op2_i, ready_i,
    input  ready_o, valid_o, res_o, branch_taken_o, illegal_o
  );
endinterface

// File: rtl/logical_unit_mc.sv
// Handshaked logical / branch-compare unit with optional multi-cycle bit counts.
// Define LOGICAL_BITCNT_EN to build CLZ/CTZ/CPOP and the COUNT/DONE states.
module logical_unit_mc #(
  parameter int XLEN  = 32,
  parameter int CHUNK = 8
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           flush_i,
  logical_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN) + 1;

  if ((XLEN % CHUNK) != 0) begin : g_chunk_check
    $error("CHUNK must divide XLEN");
  end

  typedef struct packed {
    logic [XLEN-1:0] res;
    logic            taken;
    logic            illegal;
    logic            count;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] f, input logic br,
                                  input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    dec_t d;
    sa = a;
    sb = b;
    d  = '0;
    if (br) begin
      case (f)
        4'b0000: d.taken = (a == b);
        4'b0001: d.taken = (a != b);
        4'b0100: d.taken = (sa < sb);
        4'b0101: d.taken = (sa >= sb);
        4'b0110: d.taken = (a < b);
        4'b0111: d.taken = (a >= b);
        default: d.illegal = 1'b1;
      endcase
    end else begin
      case (f)
        4'b0010: d.res = XLEN'(sa < sb);
        4'b0011: d.res = XLEN'(a < b);
        4'b0100: d.res = a ^ b;
        4'b0110: d.res = a | b;
        4'b0111: d.res = a & b;
`ifdef LOGICAL_BITCNT_EN
        4'b1000, 4'b1001, 4'b1010: d.count = 1'b1;
`endif
        default: d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

  dec_t            dec;
  logic            accept;
  logic            valid_q;
  logic [XLEN-1:0] res_q;
  logic            taken_q;
  logic            illegal_q;

  assign dec    = decode(bus.funct_i, bus.is_branch_op_i, bus.op1_i, bus.op2_i);
  assign accept = bus.valid_i & bus.ready_o;

  assign bus.valid_o        = valid_q;
  assign bus.res_o          = res_q;
  assign bus.branch_taken_o = taken_q;
  assign bus.illegal_o      = illegal_q;

`ifdef LOGICAL_BITCNT_EN
  localparam int N  = XLEN / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  function automatic logic [CW-1:0] lead_zeros(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (c[i]) hit = 1'b1;
      else if (!hit) n = n + CW'(1);
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] trail_zeros(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    logic          hit;
    n   = '0;
    hit = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (c[i]) hit = 1'b1;
      else if (!hit) n = n + CW'(1);
    end
    return n;
  endfunction

  function automatic logic [CW-1:0] pop_count(input logic [CHUNK-1:0] c);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < CHUNK; i++) n = n + CW'(c[i]);
    return n;
  endfunction

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hit_q, hit_d;
  logic [1:0]      kind_q;
  logic [CHUNK-1:0] chunk;

  assign bus.ready_o = (state_q == IDLE) & (~valid_q | bus.ready_i);

  // CLZ walks MSB-first, CTZ/CPOP LSB-first; once a set bit is seen the zero runs stop.
  always_comb begin
    chunk  = (kind_q == 2'b00) ? opnd_q[XLEN-1 -: CHUNK] : opnd_q[CHUNK-1:0];
    opnd_d = (kind_q == 2'b00) ? (opnd_q << CHUNK) : (opnd_q >> CHUNK);
    hit_d  = hit_q | (chunk != '0);
    cnt_d  = cnt_q;
    case (kind_q)
      2'b00:   if (!hit_q) cnt_d = cnt_q + lead_zeros(chunk);
      2'b01:   if (!hit_q) cnt_d = cnt_q + trail_zeros(chunk);
      default: cnt_d = cnt_q + pop_count(chunk);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (accept && dec.count) begin
      opnd_q <= bus.op1_i;
      cnt_q  <= '0;
      hit_q  <= 1'b0;
      kind_q <= bus.funct_i[1:0];
    end else if (state_q == COUNT) begin
      opnd_q <= opnd_d;
      cnt_q  <= cnt_d;
      hit_q  <= hit_d;
    end
  end
`else
  assign bus.ready_o = ~valid_q | bus.ready_i;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
`ifdef LOGICAL_BITCNT_EN
      state_q   <= IDLE;
      idx_q     <= '0;
`endif
      valid_q   <= 1'b0;
      res_q     <= '0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (flush_i) begin
`ifdef LOGICAL_BITCNT_EN
      state_q <= IDLE;
`endif
      valid_q <= 1'b0;
    end else begin
      if (bus.ready_i) valid_q <= 1'b0;
`ifdef LOGICAL_BITCNT_EN
      case (state_q)
        IDLE: begin
          if (accept && dec.count) begin
            state_q <= COUNT;
            idx_q   <= '0;
          end else if (accept) begin
            valid_q   <= 1'b1;
            res_q     <= dec.res;
            taken_q   <= dec.taken;
            illegal_q <= dec.illegal;
          end
        end
        COUNT: begin
          if (idx_q == IW'(N - 1)) state_q <= DONE;
          else idx_q <= idx_q + IW'(1);
        end
        default: begin
          valid_q   <= 1'b1;
          res_q     <= {{(XLEN-CW){1'b0}}, cnt_q};
          taken_q   <= 1'b0;
          illegal_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
`else
      if (accept) begin
        valid_q   <= 1'b1;
        res_q     <= dec.res;
        taken_q   <= dec.taken;
        illegal_q <= dec.illegal;
      end
`endif
    end
  end
endmodule

// File: tb/tb_logical_unit_mc.sv
// Directed bench for logical_unit_mc (XLEN=32, CHUNK=8); bit-count section
// follows LOGICAL_BITCNT_EN, the disabled build checks funct[3] as illegal.
module tb_logical_unit_mc;
  logic clk;
  logic rst_n;
  logic flush;
  int   checks;
  int   failures;

  logical_unit_if #(.XLEN(32)) bus ();

  logical_unit_mc #(.XLEN(32), .CHUNK(8)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .flush_i (flush),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] f, input logic br,
                       input logic [31:0] a, input logic [31:0] b);
    bus.valid_i        = 1'b1;
    bus.funct_i        = f;
    bus.is_branch_op_i = br;
    bus.op1_i          = a;
    bus.op2_i          = b;
  endtask

  task automatic idle();
    bus.valid_i = 1'b0;
    bus.funct_i = 4'b0000;
    bus.op1_i   = 32'h0;
    bus.op2_i   = 32'h0;
  endtask

`ifdef LOGICAL_BITCNT_EN
  task automatic count_op(input string tag, input logic [3:0] f,
                          input logic [31:0] a, input logic [31:0] exp);
    issue(f, 1'b0, a, 32'h0);
    step();
    idle();
    for (int i = 0; i < 4; i++) begin
      chkb({tag, "_busy_ready"}, bus.ready_o, 1'b0);
      chkb({tag, "_busy_valid"}, bus.valid_o, 1'b0);
      step();
    end
    chkb({tag, "_done_ready"}, bus.ready_o, 1'b0);
    step();
    chkb({tag, "_valid"}, bus.valid_o, 1'b1);
    chk({tag, "_res"}, bus.res_o, exp);
    chkb({tag, "_illegal"}, bus.illegal_o, 1'b0);
  endtask
`endif

  initial begin
    checks             = 0;
    failures           = 0;
    rst_n              = 1'b0;
    flush              = 1'b0;
    bus.ready_i        = 1'b0;
    bus.is_branch_op_i = 1'b0;
    idle();
    step();
    step();
    chkb("rst_valid", bus.valid_o, 1'b0);
    chk("rst_res", bus.res_o, 32'h0);
    chkb("rst_taken", bus.branch_taken_o, 1'b0);
    chkb("rst_illegal", bus.illegal_o, 1'b0);
    rst_n       = 1'b1;
    bus.ready_i = 1'b1;
    step();
    chkb("idle_ready", bus.ready_o, 1'b1);

    // Compares and logic, issued back to back
    issue(4'b0010, 1'b0, 32'hFFFF_FFFF, 32'h1);
    step();
    chkb("slt_valid", bus.valid_o, 1'b1);
    chk("slt_res", bus.res_o, 32'h1);
    issue(4'b0011, 1'b0, 32'hFFFF_FFFF, 32'h1);
    step();
    chkb("sltu_valid", bus.valid_o, 1'b1);
    chk("sltu_res", bus.res_o, 32'h0);
    issue(4'b0100, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000);
    step();
    chkb("xor_valid", bus.valid_o, 1'b1);
    chk("xor_res", bus.res_o, 32'h0F0F_F0F0);
    idle();
    step();
    chkb("drain_valid", bus.valid_o, 1'b0);

    // Branches
    issue(4'b0101, 1'b1, 32'h8000_0000, 32'h0);
    step();
    chkb("ge_taken", bus.branch_taken_o, 1'b0);
    chk("ge_res", bus.res_o, 32'h0);
    issue(4'b0111, 1'b1, 32'h8000_0000, 32'h0);
    step();
    chkb("geu_taken", bus.branch_taken_o, 1'b1);
    chk("geu_res", bus.res_o, 32'h0);
    issue(4'b0010, 1'b1, 32'h1234_5678, 32'h0);
    step();
    chkb("br_ill_illegal", bus.illegal_o, 1'b1);
    chkb("br_ill_taken", bus.branch_taken_o, 1'b0);
    issue(4'b0100, 1'b1, 32'hFFFF_FFFE, 32'h1);
    step();
    chkb("lt_taken", bus.branch_taken_o, 1'b1);
    chkb("lt_illegal", bus.illegal_o, 1'b0);
    issue(4'b0001, 1'b1, 32'h5, 32'h5);
    step();
    chkb("ne_taken", bus.branch_taken_o, 1'b0);
    idle();
    bus.is_branch_op_i = 1'b0;
    step();

    // Output hold under back-pressure, then drain + accept together
    bus.ready_i = 1'b0;
    issue(4'b0110, 1'b0, 32'h00FF_00F0, 32'h0F00_0F00);
    step();
    chkb("or_valid", bus.valid_o, 1'b1);
    chk("or_res", bus.res_o, 32'h0FFF_0FF0);
    issue(4'b0111, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F);
    for (int i = 0; i < 3; i++) begin
      chkb("hold_ready", bus.ready_o, 1'b0);
      step();
      chkb("hold_valid", bus.valid_o, 1'b1);
      chk("hold_res", bus.res_o, 32'h0FFF_0FF0);
    end
    bus.ready_i = 1'b1;
    #1;
    chkb("drain_ready", bus.ready_o, 1'b1);
    step();
    chkb("and_valid", bus.valid_o, 1'b1);
    chk("and_res", bus.res_o, 32'h0F0F_0000);
    idle();
    step();
    chkb("and_drained", bus.valid_o, 1'b0);

    // Flush kills a pending output and drops the same-cycle accept
    issue(4'b0100, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000);
    step();
    chkb("pre_flush_valid", bus.valid_o, 1'b1);
    bus.ready_i = 1'b0;
    flush       = 1'b1;
    issue(4'b0110, 1'b0, 32'h0, 32'h1);
    step();
    chkb("flush_valid", bus.valid_o, 1'b0);
    flush       = 1'b0;
    bus.ready_i = 1'b1;
    idle();
    step();
    chkb("post_flush_valid", bus.valid_o, 1'b0);
    chkb("post_flush_ready", bus.ready_o, 1'b1);

`ifdef LOGICAL_BITCNT_EN
    count_op("clz", 4'b1000, 32'h0001_0000, 32'd15);
    count_op("ctz", 4'b1001, 32'h0001_0000, 32'd16);
    count_op("cpop", 4'b1010, 32'hFFFF_FFFF, 32'd32);
    count_op("clz0", 4'b1000, 32'h0, 32'd32);
    count_op("ctz0", 4'b1001, 32'h0, 32'd32);
    count_op("cpop9", 4'b1010, 32'h0F0F_0001, 32'd9);
    idle();
    step();

    issue(4'b1001, 1'b0, 32'h1, 32'h0);
    step();
    idle();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chkb("cnt_flush_ready", bus.ready_o, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chkb("cnt_flush_valid", bus.valid_o, 1'b0);
      step();
    end

    issue(4'b1000, 1'b0, 32'h1, 32'h0);
    step();
    idle();
    step();
`else
    issue(4'b1010, 1'b0, 32'hFFFF_FFFF, 32'h0);
    step();
    chkb("cpop_off_valid", bus.valid_o, 1'b1);
    chkb("cpop_off_illegal", bus.illegal_o, 1'b1);
    chk("cpop_off_res", bus.res_o, 32'h0);
    issue(4'b0111, 1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F);
    step();
    chk("and_off_res", bus.res_o, 32'h0F0F_0000);
    chkb("and_off_illegal", bus.illegal_o, 1'b0);
    issue(4'b0110, 1'b0, 32'h00FF_00F0, 32'h0F00_0F00);
    step();
    idle();
    chkb("pre_rst_valid", bus.valid_o, 1'b1);
`endif

    // Asynchronous reset while busy
    rst_n = 1'b0;
    #1;
    chkb("mid_rst_valid", bus.valid_o, 1'b0);
    chk("mid_rst_res", bus.res_o, 32'h0);
    chkb("mid_rst_taken", bus.branch_taken_o, 1'b0);
    chkb("mid_rst_illegal", bus.illegal_o, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    chkb("post_rst_ready", bus.ready_o, 1'b1);
    issue(4'b0100, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_0000);
    step();
    idle();
    chkb("post_rst_xor_valid", bus.valid_o, 1'b1);
    chk("post_rst_xor_res", bus.res_o, 32'h0F0F_F0F0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
